// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter: default widths, FSM state
// encoding and the width helper for the write-buffer fill level.
package vram_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RDW  = 2'd3
    } vram_state_e;

    // A level counter must hold 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// CPU write buffer: one entry per address/data pair, first-in first-out.
// The caller guarantees no push while full and no pop while empty.
module vram_wr_fifo
    import vram_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [AW-1:0]                 push_addr,
    input  logic [DW-1:0]                 push_data,
    input  logic                          pop,
    output logic [AW-1:0]                 head_addr,
    output logic [DW-1:0]                 head_data,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    // Next-state for storage, pointers and fill level.
    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            addr_d[wr_ptr_q] = push_addr;
            data_d[wr_ptr_q] = push_data;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage and pointer registers; reset discards all buffered writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);
    assign level     = level_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetches always win the RAM port; CPU
// writes are buffered and retired in free cycles; CPU reads wait for all
// older buffered writes so read-after-write stays coherent.
// Optional VRAM_STARVE_GUARD_EN: steals one display slot after the write
// buffer has been full for MAX_WAIT display cycles, flagged by disp_glitch.
//
// state | meaning
// IDLE  | nothing in progress; picks buffered write first, then read
// WR    | retiring the write-buffer head in each free cycle
// RD    | read waiting for a free cycle to drive its address
// RDW   | read data returning from RAM; captured and reported
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int FIFO_DEPTH = 4
`ifdef VRAM_STARVE_GUARD_EN
    ,
    parameter int MAX_WAIT   = 255
`endif
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               disp_req,
    input  logic [AW-1:0]                      disp_addr,
    output logic [DW-1:0]                      disp_data,
    input  logic                               cpu_wr_valid,
    output logic                               cpu_wr_ready,
    input  logic [AW-1:0]                      cpu_wr_addr,
    input  logic [DW-1:0]                      cpu_wr_data,
    input  logic                               cpu_rd_valid,
    output logic                               cpu_rd_ready,
    input  logic [AW-1:0]                      cpu_rd_addr,
    output logic [DW-1:0]                      cpu_rd_data,
    output logic                               cpu_rd_done,
    output logic [AW-1:0]                      mem_addr,
    output logic [DW-1:0]                      mem_wdata,
    output logic                               mem_we,
    input  logic [DW-1:0]                      mem_rdata,
    output logic [level_width(FIFO_DEPTH)-1:0] fifo_level
`ifdef VRAM_STARVE_GUARD_EN
    ,
    output logic                               disp_glitch
`endif
);

    localparam int LW = level_width(FIFO_DEPTH);

    vram_state_e   state_q, state_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic          push;
    logic          pop;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          steal;

    assign cpu_wr_ready = ~fifo_full;
    assign push         = cpu_wr_valid & cpu_wr_ready;
    assign disp_data    = mem_rdata;

    vram_wr_fifo #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (cpu_wr_addr),
        .push_data (cpu_wr_data),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

`ifdef VRAM_STARVE_GUARD_EN
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wait_q, wait_d;

    // Starvation counter: counts display cycles that block a full buffer.
    always_comb begin
        wait_d = wait_q;
        steal  = 1'b0;
        if (disp_req && !fifo_empty && (wait_q >= CW'(MAX_WAIT))) begin
            steal  = 1'b1;
            wait_d = '0;
        end else if (disp_req && fifo_full) begin
            wait_d = wait_q + CW'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign disp_glitch = steal;
`else
    assign steal = 1'b0;
`endif

    // Arbitration FSM next-state and combinational RAM port mux.
    always_comb begin
        state_d      = state_q;
        rd_data_d    = rd_data_q;
        pop          = 1'b0;
        mem_addr     = disp_addr;
        mem_wdata    = head_data;
        mem_we       = 1'b0;
        cpu_rd_ready = 1'b0;
        cpu_rd_done  = 1'b0;
        cpu_rd_data  = rd_data_q;
        case (state_q)
            ST_IDLE: begin
                if (!disp_req) begin
                    if (!fifo_empty) begin
                        state_d = ST_WR;
                    end else if (cpu_rd_valid) begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_WR: begin
                if (!disp_req) begin
                    if (fifo_empty) begin
                        // Buffer was emptied by a stolen slot while frozen.
                        state_d = ST_IDLE;
                    end else begin
                        mem_addr = head_addr;
                        mem_we   = 1'b1;
                        pop      = 1'b1;
                        state_d  = (fifo_level > LW'(1) || push) ? ST_WR : ST_IDLE;
                    end
                end
            end
            ST_RD: begin
                if (!disp_req) begin
                    if (!fifo_empty) begin
                        // A write slipped in while waiting; drain it first.
                        state_d = ST_WR;
                    end else begin
                        mem_addr     = cpu_rd_addr;
                        cpu_rd_ready = 1'b1;
                        state_d      = ST_RDW;
                    end
                end
            end
            ST_RDW: begin
                // RAM data for the read arrives now; no RAM slot is used.
                rd_data_d   = mem_rdata;
                cpu_rd_data = mem_rdata;
                cpu_rd_done = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (steal) begin
            mem_addr = head_addr;
            mem_we   = 1'b1;
            pop      = 1'b1;
        end
    end

    // FSM state and read-result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model with 1-cycle read latency, a scoreboard
// of expected RAM writes in CPU push order, and a shadow memory giving the
// value every CPU read must return.
module tb_vram_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 3;
    localparam int TMO   = 200;

    logic          clk;
    logic          rst_n;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          cpu_wr_valid;
    logic          cpu_wr_ready;
    logic [AW-1:0] cpu_wr_addr;
    logic [DW-1:0] cpu_wr_data;
    logic          cpu_rd_valid;
    logic          cpu_rd_ready;
    logic [AW-1:0] cpu_rd_addr;
    logic [DW-1:0] cpu_rd_data;
    logic          cpu_rd_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic [LW-1:0] fifo_level;

    vram_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_data    (disp_data),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_ready (cpu_wr_ready),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_rd_valid (cpu_rd_valid),
        .cpu_rd_ready (cpu_rd_ready),
        .cpu_rd_addr  (cpu_rd_addr),
        .cpu_rd_data  (cpu_rd_data),
        .cpu_rd_done  (cpu_rd_done),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata),
        .fifo_level   (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;

    // Power-up RAM contents: a fixed pattern, with 0xA5 at 0x0102.
    function automatic logic [7:0] init_val(input logic [15:0] a);
        if (a == 16'h0102) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    logic [7:0] ram [int];
    logic [7:0] shadow [int];

    function automatic logic [7:0] ram_rd(input logic [15:0] a);
        if (ram.exists(int'(a))) return ram[int'(a)];
        return init_val(a);
    endfunction

    function automatic logic [7:0] shadow_rd(input logic [15:0] a);
        if (shadow.exists(int'(a))) return shadow[int'(a)];
        return init_val(a);
    endfunction

    // RAM model: synchronous read (old data on read-during-write).
    always @(posedge clk) begin
        mem_rdata <= ram_rd(mem_addr);
        if (mem_we) ram[int'(mem_addr)] = mem_wdata;
    end

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t        exp_wq[$];
    int         we_times[$];
    logic       rd_pend = 1'b0;
    logic [7:0] rd_exp;

    always @(negedge rst_n) begin
        exp_wq.delete();
        rd_pend = 1'b0;
    end

    // Scoreboard: display priority, write order/content, read coherence.
    always @(negedge clk) begin
        wr_t w;
        cyc++;
        if (rst_n) begin
            checks++;
            if (disp_data !== mem_rdata) begin
                errors++;
                $display("FAIL disp_passthru: got %h want %h", disp_data, mem_rdata);
            end
            if (disp_req) begin
                checks++;
                if (mem_we !== 1'b0 || mem_addr !== disp_addr) begin
                    errors++;
                    $display("FAIL disp_priority: we=%b addr=%h want we=0 addr=%h",
                             mem_we, mem_addr, disp_addr);
                end
            end
            if (mem_we === 1'b1) begin
                we_times.push_back(cyc);
                checks++;
                if (exp_wq.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_write: addr=%h data=%h want none", mem_addr, mem_wdata);
                end else begin
                    w = exp_wq.pop_front();
                    if (mem_addr !== w.a || mem_wdata !== w.d) begin
                        errors++;
                        $display("FAIL write_order: got %h/%h want %h/%h",
                                 mem_addr, mem_wdata, w.a, w.d);
                    end
                end
            end
            if (cpu_rd_done === 1'b1) begin
                done_cnt++;
                checks++;
                if (!rd_pend) begin
                    errors++;
                    $display("FAIL rd_done_unexpected: got done=1 want 0");
                end else if (cpu_rd_data !== rd_exp) begin
                    errors++;
                    $display("FAIL rd_data: got %h want %h", cpu_rd_data, rd_exp);
                end
                rd_pend = 1'b0;
            end
            if (cpu_rd_ready === 1'b1) begin
                checks++;
                if (disp_req !== 1'b0 || exp_wq.size() != 0) begin
                    errors++;
                    $display("FAIL rd_issue: disp_req=%b pending_writes=%0d want 0/0",
                             disp_req, exp_wq.size());
                end
                rd_exp  = shadow_rd(cpu_rd_addr);
                rd_pend = 1'b1;
            end
            if (cpu_wr_valid && cpu_wr_ready) begin
                exp_wq.push_back({cpu_wr_addr, cpu_wr_data});
                shadow[int'(cpu_wr_addr)] = cpu_wr_data;
            end
        end
    end

    task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
        int n = 0;
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = a;
        cpu_wr_data  = d;
        @(negedge clk);
        while (!cpu_wr_ready && n < TMO) begin
            n++;
            @(negedge clk);
        end
        if (n >= TMO) begin
            checks++;
            errors++;
            $display("FAIL wr_timeout: ready=%b want 1", cpu_wr_ready);
        end
        @(posedge clk);
        #1 cpu_wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, output logic [7:0] got);
        int n = 0;
        got          = 'x;
        cpu_rd_valid = 1'b1;
        cpu_rd_addr  = a;
        @(negedge clk);
        while (!cpu_rd_ready && n < TMO) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1 cpu_rd_valid = 1'b0;
        if (n >= TMO) begin
            checks++;
            errors++;
            $display("FAIL rd_accept_timeout: ready=%b want 1", cpu_rd_ready);
            return;
        end
        n = 0;
        @(negedge clk);
        while (!cpu_rd_done && n < TMO) begin
            n++;
            @(negedge clk);
        end
        if (n >= TMO) begin
            checks++;
            errors++;
            $display("FAIL rd_done_timeout: done=%b want 1", cpu_rd_done);
        end
        got = cpu_rd_data;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((fifo_level != 0 || rd_pend) && n < TMO) begin
            n++;
            @(negedge clk);
        end
        if (n >= TMO) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: level=%0d want 0", fifo_level);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        disp_req = 1'b0; disp_addr = '0;
        cpu_wr_valid = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
        cpu_rd_valid = 1'b0; cpu_rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem_we !== 1'b0 || cpu_wr_ready !== 1'b1 || cpu_rd_ready !== 1'b0 ||
            cpu_rd_done !== 1'b0 || cpu_rd_data !== 8'h00 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL reset_values: we=%b wr_rdy=%b rd_rdy=%b done=%b rdata=%h lvl=%0d want 0 1 0 0 00 0",
                     mem_we, cpu_wr_ready, cpu_rd_ready, cpu_rd_done, cpu_rd_data, fifo_level);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_display_hold();
        disp_req  = 1'b1;
        disp_addr = 16'h0102;
        we_times.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (disp_data !== 8'hA5) begin
            errors++;
            $display("FAIL disp_data: got %h want a5", disp_data);
        end
        @(posedge clk);
        #1;
        push_wr(16'h0500, 8'h77);
        repeat (5) @(negedge clk);
        checks++;
        if (fifo_level !== 3'd1 || we_times.size() != 0) begin
            errors++;
            $display("FAIL display_hold: level=%0d writes=%0d want 1/0", fifo_level, we_times.size());
        end
        @(posedge clk);
        #1 disp_req = 1'b0;
        drain();
    endtask

    task automatic test_burst();
        we_times.delete();
        disp_req = 1'b0;
        for (int i = 0; i < 4; i++) push_wr(16'h0200 + 16'(i), 8'h11 * 8'(i + 1));
        drain();
        checks++;
        if (we_times.size() != 4) begin
            errors++;
            $display("FAIL burst_count: got %0d writes want 4", we_times.size());
        end else if (we_times[3] - we_times[0] != 3) begin
            errors++;
            $display("FAIL burst_consecutive: span %0d cycles want 3", we_times[3] - we_times[0]);
        end
        checks++;
        if (fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL burst_level: got %0d want 0", fifo_level);
        end
    endtask

    task automatic test_full();
        int n = 0;
        we_times.delete();
        disp_req  = 1'b1;
        disp_addr = 16'h0102;
        for (int i = 0; i < 4; i++) push_wr(16'h0800 + 16'(i), 8'hC0 + 8'(i));
        @(negedge clk);
        checks++;
        if (cpu_wr_ready !== 1'b0 || fifo_level !== 3'd4) begin
            errors++;
            $display("FAIL full_flag: ready=%b level=%0d want 0/4", cpu_wr_ready, fifo_level);
        end
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = 16'h0804;
        cpu_wr_data  = 8'hC4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (cpu_wr_ready !== 1'b0) begin
                errors++;
                $display("FAIL fifth_held: ready=%b want 0", cpu_wr_ready);
            end
        end
        @(posedge clk);
        #1 disp_req = 1'b0;
        @(negedge clk);
        while (!cpu_wr_ready && n < TMO) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1 cpu_wr_valid = 1'b0;
        drain();
        checks++;
        if (we_times.size() != 5) begin
            errors++;
            $display("FAIL full_drain: got %0d writes want 5", we_times.size());
        end
    endtask

    task automatic test_raw();
        logic [7:0] got;
        disp_req = 1'b0;
        push_wr(16'h0400, 8'h3C);
        do_read(16'h0400, got);
        checks++;
        if (got !== 8'h3C) begin
            errors++;
            $display("FAIL raw_read: got %h want 3c", got);
        end
        drain();
    endtask

    task automatic test_interleave();
        logic [7:0] got;
        disp_req = 1'b0;
        fork
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    disp_req  = ~disp_req;
                    disp_addr = 16'($urandom);
                end
            end
            begin
                push_wr(16'h0700, 8'h5A);
                do_read(16'h0700, got);
                checks++;
                if (got !== 8'h5A) begin
                    errors++;
                    $display("FAIL interleave_read: got %h want 5a", got);
                end
            end
        join
        disp_req = 1'b0;
        drain();
    endtask

    task automatic test_random();
        logic [7:0] got;
        int start_done;
        int nreads = 0;
        start_done = done_cnt;
        fork
            begin
                repeat (300) begin
                    @(posedge clk);
                    #1;
                    disp_req  = ($urandom_range(0, 3) != 0);
                    disp_addr = 16'($urandom);
                end
                disp_req = 1'b0;
            end
            begin
                repeat (40) begin
                    if ($urandom_range(0, 2) == 0) begin
                        do_read(16'h0600 + 16'($urandom_range(0, 7)), got);
                        nreads++;
                    end else begin
                        push_wr(16'h0600 + 16'($urandom_range(0, 7)), 8'($urandom));
                    end
                end
            end
        join
        disp_req = 1'b0;
        drain();
        checks++;
        if (done_cnt - start_done != nreads || exp_wq.size() != 0) begin
            errors++;
            $display("FAIL random_totals: done=%0d left=%0d want %0d/0",
                     done_cnt - start_done, exp_wq.size(), nreads);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int snap;
        disp_req     = 1'b0;
        cpu_rd_valid = 1'b1;
        cpu_rd_addr  = 16'h0600;
        @(negedge clk);
        while (!cpu_rd_ready && n < TMO) begin
            n++;
            @(negedge clk);
        end
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = 16'h0610;
        cpu_wr_data  = 8'hE1;
        @(posedge clk);
        #1;
        cpu_rd_valid = 1'b0;
        cpu_wr_addr  = 16'h0611;
        cpu_wr_data  = 8'hE2;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || cpu_wr_ready !== 1'b1 || cpu_rd_ready !== 1'b0 ||
            cpu_rd_done !== 1'b0 || cpu_rd_data !== 8'h00 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_values: we=%b wr_rdy=%b rd_rdy=%b done=%b rdata=%h lvl=%0d want 0 1 0 0 00 0",
                     mem_we, cpu_wr_ready, cpu_rd_ready, cpu_rd_done, cpu_rd_data, fifo_level);
        end
        cpu_wr_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        snap = done_cnt;
        we_times.delete();
        repeat (10) @(negedge clk);
        checks++;
        if (we_times.size() != 0 || done_cnt != snap) begin
            errors++;
            $display("FAIL reset_mid_stale: writes=%0d dones=%0d want 0/0",
                     we_times.size(), done_cnt - snap);
        end
    endtask

    initial begin
        test_reset();
        test_display_hold();
        test_burst();
        test_full();
        test_raw();
        test_interleave();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
